// File: rtl/program_loader.sv
// Boot loader for the LC2K CPU: takes a length-prefixed, checksummed byte stream,
// writes its 32-bit words into instruction memory and releases the PC reset once the checksum matches.
module program_loader #(
  parameter int DEPTH      = 65536,
  parameter int ADDR_W     = 16,
  parameter int RESET_HOLD = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  input  logic              i_halt,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_reset,
  output logic              o_loaded,
  output logic              o_error
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_WORD,
    S_CHECK,
    S_HOLD,
    S_RUN,
    S_ERROR
  } state_t;

  // A hold of zero cycles would let cpu_reset fall before the last imem write lands.
  localparam int HOLD_CYC = (RESET_HOLD < 1) ? 1 : RESET_HOLD;
  localparam int HOLD_W   = $clog2(HOLD_CYC + 1);

  state_t            r_state;
  logic              r_in_ready;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_cpu_reset;
  logic              r_loaded;
  logic              r_error;
  logic [7:0]        r_len_hi;
  logic [15:0]       r_len;
  logic [15:0]       r_word_cnt;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_word;
  logic [7:0]        r_csum;
  logic [HOLD_W-1:0] r_hold_cnt;

  logic        w_xfer;
  logic [31:0] w_word_next;
  logic [31:0] w_len_next;
  logic        w_last_word;

  assign w_xfer      = i_in_valid & r_in_ready;
  assign w_word_next = {r_word, i_in_data};
  assign w_len_next  = {16'd0, r_len_hi, i_in_data};
  assign w_last_word = (r_word_cnt == (r_len - 16'd1));

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= S_LEN_HI;
      r_in_ready   <= 1'b1;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_reset  <= 1'b1;
      r_loaded     <= 1'b0;
      r_error      <= 1'b0;
      r_len_hi     <= '0;
      r_len        <= '0;
      r_word_cnt   <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_csum       <= '0;
      r_hold_cnt   <= '0;
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len_hi <= i_in_data;
            r_state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len <= w_len_next[15:0];
            if (w_len_next > 32'(DEPTH)) begin
              r_state    <= S_ERROR;
              r_error    <= 1'b1;
              r_in_ready <= 1'b0;
            end else if (w_len_next[15:0] == 16'd0) begin
              r_state <= S_CHECK;
            end else begin
              r_state <= S_WORD;
            end
          end
        end
        S_WORD: begin
          if (w_xfer) begin
            r_word     <= w_word_next[23:0];
            r_csum     <= r_csum ^ i_in_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            // Ready stays high through the write cycle so the next word streams without a bubble.
            if (r_byte_idx == 2'd3) begin
              r_imem_we    <= 1'b1;
              r_imem_addr  <= ADDR_W'(r_word_cnt);
              r_imem_wdata <= w_word_next;
              r_word_cnt   <= r_word_cnt + 16'd1;
              if (w_last_word) begin
                r_state <= S_CHECK;
              end
            end
          end
        end
        S_CHECK: begin
          if (w_xfer) begin
            r_in_ready <= 1'b0;
            if (i_in_data == r_csum) begin
              r_state    <= S_HOLD;
              r_hold_cnt <= '0;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
            r_state     <= S_RUN;
            r_cpu_reset <= 1'b0;
            r_loaded    <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        S_RUN: begin
          // Re-arm for the next image; instruction memory is left as is.
          if (i_halt) begin
            r_state     <= S_LEN_HI;
            r_cpu_reset <= 1'b1;
            r_loaded    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_len_hi    <= '0;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_byte_idx  <= '0;
            r_word      <= '0;
            r_csum      <= '0;
            r_hold_cnt  <= '0;
          end
        end
        S_ERROR: begin
          r_error     <= 1'b1;
          r_in_ready  <= 1'b0;
          r_cpu_reset <= 1'b1;
          r_loaded    <= 1'b0;
        end
        default: begin
          r_state     <= S_ERROR;
          r_error     <= 1'b1;
          r_in_ready  <= 1'b0;
          r_cpu_reset <= 1'b1;
          r_loaded    <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;
  assign o_cpu_reset  = r_cpu_reset;
  assign o_loaded     = r_loaded;
  assign o_error      = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader: a stream-level reference model predicts
// the imem writes and the load outcome for each image, and the observed behaviour is compared against it.
module tb_program_loader;

  localparam int DEPTH      = 4;
  localparam int ADDR_W     = 16;
  localparam int RESET_HOLD = 4;

  logic              clk;
  logic              resetN;
  logic              inValid;
  logic [7:0]        inData;
  logic              inReady;
  logic              halt;
  logic              imemWe;
  logic [ADDR_W-1:0] imemAddr;
  logic [31:0]       imemWdata;
  logic              cpuReset;
  logic              loaded;
  logic              errorOut;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0]  stimBytes[$];
  logic [47:0] expWrites[$];
  logic [47:0] gotWrites[$];
  bit          expError;
  int          expConsumed;

  program_loader #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .RESET_HOLD(RESET_HOLD)
  ) dut (
    .i_clk(clk),
    .i_reset(resetN),
    .i_in_valid(inValid),
    .i_in_data(inData),
    .o_in_ready(inReady),
    .i_halt(halt),
    .o_imem_we(imemWe),
    .o_imem_addr(imemAddr),
    .o_imem_wdata(imemWdata),
    .o_cpu_reset(cpuReset),
    .o_loaded(loaded),
    .o_error(errorOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every write strobe away from the active edge.
  always @(negedge clk) begin
    if (imemWe) gotWrites.push_back({imemAddr, imemWdata});
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: interpret the stream by its format rules.
  task automatic computeExpected();
    int n;
    logic [7:0] sum;
    expWrites.delete();
    n = {stimBytes[0], stimBytes[1]};
    sum = 8'h00;
    if (n > DEPTH) begin
      expError = 1'b1;
      expConsumed = 2;
    end else begin
      for (int w = 0; w < n; w++) begin
        logic [31:0] word;
        word = {stimBytes[2+4*w], stimBytes[3+4*w], stimBytes[4+4*w], stimBytes[5+4*w]};
        for (int k = 0; k < 4; k++) sum = sum ^ stimBytes[2+4*w+k];
        expWrites.push_back({16'(w), word});
      end
      expConsumed = 2 + 4*n + 1;
      expError = (stimBytes[2+4*n] != sum);
    end
  endtask

  // Offer one byte from a negedge; report whether it was taken within maxWait cycles.
  task automatic sendByte(input logic [7:0] b, input bit gaps, input int maxWait, output bit accepted);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        inData = 8'($urandom);
        halt = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    inValid = 1'b1;
    inData = b;
    halt = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
    n = 0;
    while (!inReady && n < maxWait) begin
      @(negedge clk);
      n++;
    end
    if (inReady) begin
      @(negedge clk);
      accepted = 1'b1;
    end else begin
      accepted = 1'b0;
    end
    inValid = 1'b0;
    inData = 8'($urandom);
    halt = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    resetN = 1'b0;
    inValid = 1'b0;
    halt = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(inReady), 32'd1);
    checkOutput("rst_imem_we", 32'(imemWe), 32'd0);
    checkOutput("rst_imem_addr", 32'(imemAddr), 32'd0);
    checkOutput("rst_imem_wdata", imemWdata, 32'd0);
    checkOutput("rst_cpu_reset", 32'(cpuReset), 32'd1);
    checkOutput("rst_loaded", 32'(loaded), 32'd0);
    checkOutput("rst_error", 32'(errorOut), 32'd0);
    resetN = 1'b1;
    gotWrites.delete();
  endtask

  // Send an image, check the outcome timing, then compare the write log.
  task automatic applyStimulus(input bit gaps, input string name);
    bit acc;
    computeExpected();
    gotWrites.delete();
    for (int i = 0; i < expConsumed; i++) begin
      sendByte(stimBytes[i], gaps, 50, acc);
      checkOutput({name, "_accept"}, 32'(acc), 32'd1);
    end
    if (expError) begin
      checkOutput({name, "_error"}, 32'(errorOut), 32'd1);
      checkOutput({name, "_err_ready"}, 32'(inReady), 32'd0);
      checkOutput({name, "_err_cpurst"}, 32'(cpuReset), 32'd1);
      checkOutput({name, "_err_loaded"}, 32'(loaded), 32'd0);
      sendByte(8'hAA, 1'b0, 6, acc);
      checkOutput({name, "_err_noaccept"}, 32'(acc), 32'd0);
      checkOutput({name, "_err_sticky"}, 32'(errorOut), 32'd1);
      checkOutput({name, "_err_cpurst2"}, 32'(cpuReset), 32'd1);
    end else begin
      for (int k = 0; k < RESET_HOLD; k++) begin
        checkOutput({name, "_hold_cpurst"}, 32'(cpuReset), 32'd1);
        checkOutput({name, "_hold_ready"}, 32'(inReady), 32'd0);
        @(negedge clk);
      end
      checkOutput({name, "_run_cpurst"}, 32'(cpuReset), 32'd0);
      checkOutput({name, "_run_loaded"}, 32'(loaded), 32'd1);
      checkOutput({name, "_run_error"}, 32'(errorOut), 32'd0);
      checkOutput({name, "_run_ready"}, 32'(inReady), 32'd0);
    end
    repeat (2) @(negedge clk);
    checkOutput({name, "_nwrites"}, 32'(gotWrites.size()), 32'(expWrites.size()));
    for (int i = 0; i < expWrites.size() && i < gotWrites.size(); i++) begin
      checkOutput({name, "_waddr"}, 32'(gotWrites[i][47:32]), 32'(expWrites[i][47:32]));
      checkOutput({name, "_wdata"}, gotWrites[i][31:0], expWrites[i][31:0]);
    end
  endtask

  task automatic loadGoodImage(input logic [7:0] last);
    stimBytes = '{8'h00, 8'h02, 8'h00, 8'h81, 8'h00, 8'h07, 8'h01, 8'hC0, 8'h00, 8'h00, last};
  endtask

  initial begin
    bit acc;
    resetN = 1'b0;
    inValid = 1'b0;
    inData = 8'h00;
    halt = 1'b0;
    repeat (2) @(negedge clk);

    applyReset();
    loadGoodImage(8'h47);
    applyStimulus(1'b0, "good");

    applyReset();
    loadGoodImage(8'h48);
    applyStimulus(1'b0, "badsum");

    applyReset();
    stimBytes = '{8'h00, 8'h00, 8'h00};
    applyStimulus(1'b0, "empty");

    applyReset();
    stimBytes = '{8'h00, 8'h05};
    applyStimulus(1'b0, "oversize");

    applyReset();
    loadGoodImage(8'h47);
    applyStimulus(1'b1, "bp");
    // Halt must only be honoured in RUN; here it re-arms the loader.
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    checkOutput("halt_cpurst", 32'(cpuReset), 32'd1);
    checkOutput("halt_loaded", 32'(loaded), 32'd0);
    checkOutput("halt_ready", 32'(inReady), 32'd1);
    stimBytes = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    applyStimulus(1'b1, "second");

    applyReset();
    loadGoodImage(8'h47);
    for (int i = 0; i < 4; i++) begin
      sendByte(stimBytes[i], 1'b0, 50, acc);
      checkOutput("midrst_accept", 32'(acc), 32'd1);
    end
    applyReset();
    checkOutput("midrst_nowrite", 32'(gotWrites.size()), 32'd0);
    applyStimulus(1'b0, "reload");

    // Random images, including oversize lengths and corrupted checksums.
    for (int t = 0; t < 10; t++) begin
      int n;
      logic [7:0] sum;
      logic [7:0] b;
      applyReset();
      n = $urandom_range(0, DEPTH + 1);
      stimBytes.delete();
      stimBytes.push_back(8'(n >> 8));
      stimBytes.push_back(8'(n));
      sum = 8'h00;
      for (int i = 0; i < 4*n; i++) begin
        b = 8'($urandom);
        sum = sum ^ b;
        stimBytes.push_back(b);
      end
      if ($urandom_range(0, 3) == 0) sum = sum ^ (8'h01 << $urandom_range(0, 7));
      stimBytes.push_back(sum);
      applyStimulus(1'b1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    errorCount++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time front end that sits upstream of the single-cycle LC2K CPU.
- Receives a program image as a byte stream over a valid/ready handshake.
- Assembles 32-bit instruction words and writes them into instruction memory through a write port.
- Holds the CPU's PC reset asserted until the image is loaded and its checksum verifies. It re-arms for a new image when the CPU halts.

Parameters:
- DEPTH, 65536: instruction-memory capacity in words; an image longer than this is rejected.
- ADDR_W, 16: width of imem_addr.
- RESET_HOLD, 4: cycles cpu_reset stays asserted after a good checksum before release (minimum 1).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  upstream byte valid
- in_data  in  8  upstream byte
- in_ready  out  1  loader can accept a byte; transfer occurs when in_valid && in_ready at clk edge
- halt  in  1  CONTROL_HALT from control ROM
- imem_we  out  1  one-cycle instruction-memory write strobe
- imem_addr  out  ADDR_W  word address of write
- imem_wdata  out  32  word to write
- cpu_reset  out  1  active-high reset to Program_Counter
- loaded  out  1  image accepted, CPU running
- error  out  1  image rejected (sticky until reset)

Behaviour:
- Reset (reset==0 at edge): state=LEN_HI, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, loaded=0, error=0. Word counter, byte index, length and checksum accumulator are cleared. A partial word is discarded. Reset mid-load or mid-run is legal and always returns to these values.
- Stream format:
  - LEN_HI byte, then LEN_LO byte, giving a 16-bit word count N (big-endian).
  - N words, 4 bytes each, MSB first.
  - 1 checksum byte equal to the XOR of all data bytes. Length bytes are excluded from the checksum.
- States:
  - LEN_HI: accept byte -> len[15:8]; go to LEN_LO.
  - LEN_LO: accept byte -> len[7:0].
    - N > DEPTH -> ERROR.
    - N == 0 -> CHECK.
    - Otherwise -> WORD.
  - WORD:
    - Each accepted byte shifts into the word register and XORs into the checksum.
    - byte_idx counts 0..3 and wraps to 0.
    - On the accepted byte with byte_idx==3: next cycle imem_we=1 for exactly one cycle, imem_addr=word_cnt, imem_wdata=assembled word; word_cnt increments.
    - After word N-1, go to CHECK.
    - in_ready stays 1 during the write cycle, so back-to-back bytes are accepted with no bubble.
  - CHECK: accept one byte.
    - Equal to checksum -> HOLD.
    - Otherwise -> ERROR.
  - HOLD:
    - in_ready=0, cpu_reset=1; count RESET_HOLD cycles, then -> RUN.
    - The final imem write is guaranteed to complete before cpu_reset falls.
  - RUN: cpu_reset=0, loaded=1, in_ready=0. When halt==1 at an edge -> LEN_HI. On that transition: cpu_reset=1, loaded=0, in_ready=1 next cycle, all counters and checksum cleared, imem contents untouched.
  - ERROR: error=1, in_ready=0, cpu_reset=1, imem_we=0; exit only by reset.
- In_data is ignored when in_valid==0 or in_ready==0. Stalls of any length between bytes do not alter state.
- halt is ignored in all states other than RUN.
- imem_addr/imem_wdata hold their last written values when imem_we==0.
- imem_addr wraps only modulo 2^ADDR_W. The wrap cannot occur for legal N ≤ DEPTH.

Test Plan:
1. Good load: bytes 00 02 | 00 81 00 07 | 01 C0 00 00 | 47, in_valid constant. Required response:
   - imem_we pulses with addr 0 data 0x00810007.
   - imem_we pulses with addr 1 data 0x01C00000.
   - cpu_reset stays 1 for RESET_HOLD cycles after the checksum byte, then 0; loaded=1; error=0.
2. Bad checksum: same image with last byte 48. Required response:
   - Both writes occur.
   - Then error=1, in_ready=0, cpu_reset=1, loaded=0; these hold until reset.
3. Empty image: 00 00 00. Required response: no imem_we; HOLD then RUN; loaded=1.
4. Oversize with DEPTH=4: 00 05. Required response: error=1 on the cycle after the second byte; no imem_we; further bytes not accepted.
5. Backpressure and halt:
   - Repeat scenario 1 with in_valid toggled randomly; writes are identical.
   - Then assert halt in RUN: cpu_reset=1, loaded=0, in_ready=1 on the next cycle.
   - A second image 00 01 | 12 34 56 78 | 08 then loads addr 0 = 0x12345678.
6. Reset mid-word: drive reset low after 2 bytes of word 0 in scenario 1. Required response:
   - All outputs take their reset values.
   - Reloading the full image produces exactly the writes of scenario 1.
